dmem_dma: RTL and testbench
===========================

DMEM_DMA -- requirements
Module: dmem_dma

Interface
REQ-001 Parameter LENWIDTH, default 16: width of the word-count input.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  sampled every cycle; launches a copy when the block is idle.
REQ-005 src_addr  input  32  byte address of the first source word; bits [1:0] ignored.
REQ-006 dst_addr  input  32  byte address of the first destination word; bits [1:0] ignored.
REQ-007 len  input  LENWIDTH  number of 32-bit words to copy.
REQ-008 hold  input  1  when high, no new read is issued.
REQ-009 busy  output  1  high while a copy is in progress.
REQ-010 done  output  1  one-cycle pulse when a copy completes.
REQ-011 dmem_rd_addr  output  32  read byte address.
REQ-012 dmem_rd_req  output  1  read request.
REQ-013 dmem_rd_data  input  32  read data, valid in the cycle after dmem_rd_req.
REQ-014 dmem_wr_addr  output  32  write byte address.
REQ-015 dmem_wr_data  output  32  write data.
REQ-016 dmem_wr_be  output  4  write byte enables.
REQ-017 dmem_wr_req  output  1  write request.

Function
REQ-018 States: IDLE, RUN, DRAIN, FIN.
- In IDLE, start=1 latches src_addr, dst_addr (both with [1:0] forced to 0) and len, then moves to RUN.
- If the latched len is 0, the block moves to FIN instead and performs no bus activity.
REQ-019 start is ignored in every state other than IDLE; the latched parameters do not change during a copy.
REQ-020 In RUN with hold=0:
- drive dmem_rd_req=1 and dmem_rd_addr=current source address;
- then add 4 to the source address and subtract 1 from the remaining count.
REQ-021 In RUN with hold=1, dmem_rd_req=0 and the read address and remaining count do not change.
REQ-022 When RUN issues the last read (remaining count 1, hold=0), the next state is DRAIN.
REQ-023 Write pipeline:
- dmem_wr_req in cycle N+1 equals dmem_rd_req in cycle N (one register stage);
- in that cycle dmem_wr_addr=current destination address and dmem_wr_data=dmem_rd_data, passed through combinationally;
- the destination address then advances by 4.
REQ-024 dmem_wr_be=4'hF when dmem_wr_req=1, otherwise 4'h0.
REQ-025 DRAIN performs the final write and moves to FIN.
REQ-026 FIN asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-027 busy=1 in RUN and DRAIN only, and 0 in IDLE and FIN.
REQ-028 Cycle timing with no hold, start sampled at the end of cycle T and len=L≥1:
- reads occur in cycles T+1..T+L;
- writes occur in cycles T+2..T+L+1;
- done=1 in cycle T+L+2;
- throughput is one word per cycle.
REQ-029 A write to an address in the same cycle as a read of that address is permitted; the memory's bypass supplies ordering, and the block performs no hazard checks.
REQ-030 Address increments wrap modulo 2^32; the count does not wrap because the copy stops when the count reaches 0.
REQ-031 dmem_rd_addr and dmem_wr_addr hold their last values when the matching request is 0.
REQ-032 Overlap: a new start is accepted in the IDLE cycle that follows FIN, never earlier.

Reset
REQ-033 While reset=1 at a clock edge, the next state is IDLE and the following outputs take their reset values: busy=0, done=0, dmem_rd_req=0, dmem_wr_req=0, dmem_wr_be=0, dmem_rd_addr=0, dmem_wr_addr=0.
REQ-034 Reset during RUN or DRAIN abandons the copy with no further bus requests; a write already driven in the reset cycle is not suppressed retroactively.
REQ-035 start asserted in the same cycle as reset is ignored.

Verification
REQ-036 Basic copy: src=0x100, dst=0x200, len=4, memory at 0x100..0x10C = A,B,C,D -> reads at 0x100/104/108/10C in T+1..T+4; writes of A..D to 0x200..0x20C in T+2..T+5 with be=F; done pulse in T+6.
REQ-037 Zero length: start with len=0 -> no rd_req or wr_req; done=1 in T+2; busy stays 0.
REQ-038 Hold: len=3 with hold=1 for the 2 cycles after the first read -> exactly 3 reads and 3 writes with a 2-cycle gap; data and addresses are correct; done arrives 2 cycles later than REQ-028.
REQ-039 Misalignment and wrap: src=0xFFFFFFFE, dst=0x13, len=2 -> reads at 0xFFFFFFFC then 0x00000000; writes at 0x10 then 0x14.
REQ-040 Restart rules: start pulsed during busy is ignored; start in the IDLE cycle right after done starts a second copy correctly.
REQ-041 Reset mid-copy: reset asserted in T+2 of a len=8 copy -> from T+3 all requests are 0, busy=0, and done never pulses.

Source files
------------

// File: rtl/dmem_dma_if.sv
// Data-memory bus between the copy engine and a single-port-style memory.
// Reads return data one cycle after the request; writes complete in the
// cycle they are requested.
interface dmem_dma_if;
    logic [31:0] dmem_rd_addr;
    logic        dmem_rd_req;
    logic [31:0] dmem_rd_data;
    logic [31:0] dmem_wr_addr;
    logic [31:0] dmem_wr_data;
    logic [3:0]  dmem_wr_be;
    logic        dmem_wr_req;

    // Copy engine side
    modport master (
        output dmem_rd_addr,
        output dmem_rd_req,
        input  dmem_rd_data,
        output dmem_wr_addr,
        output dmem_wr_data,
        output dmem_wr_be,
        output dmem_wr_req
    );

    // Memory side
    modport slave (
        input  dmem_rd_addr,
        input  dmem_rd_req,
        output dmem_rd_data,
        input  dmem_wr_addr,
        input  dmem_wr_data,
        input  dmem_wr_be,
        input  dmem_wr_req
    );
endinterface

// File: rtl/dmem_dma.sv
// Word-granular memory-to-memory copy engine.
// One read per cycle in RUN; each read's data is written back one cycle
// later with no buffering, so read data flows straight to the write port.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; parameters latched on start
//   RUN    | issuing reads (stalled while hold=1); writes trail by one
//   DRAIN  | final write of the copy, no read
//   FIN    | one-cycle done pulse, then back to IDLE
module dmem_dma #(
    parameter int LENWIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         src_addr,
    input  logic [31:0]         dst_addr,
    input  logic [LENWIDTH-1:0] len,
    input  logic                hold,
    output logic                busy,
    output logic                done,
    dmem_dma_if.master          dmem
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [LENWIDTH-1:0] cnt_q, cnt_d;
    logic                wr_req_q, wr_req_d;
    logic [31:0]         rd_addr_last_q, rd_addr_last_d;
    logic [31:0]         wr_addr_last_q, wr_addr_last_d;
    logic                rd_req;

    // State, address/count registers and the one-stage write pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            src_q          <= 32'h0;
            dst_q          <= 32'h0;
            cnt_q          <= '0;
            wr_req_q       <= 1'b0;
            rd_addr_last_q <= 32'h0;
            wr_addr_last_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            dst_q          <= dst_d;
            cnt_q          <= cnt_d;
            wr_req_q       <= wr_req_d;
            rd_addr_last_q <= rd_addr_last_d;
            wr_addr_last_q <= wr_addr_last_d;
        end
    end

    // Next-state, read issue and status outputs
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        rd_req  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        // Destination advances after each write beat; overridden on start.
        dst_d   = wr_req_q ? (dst_q + 32'd4) : dst_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr & ~32'h3;
                    dst_d   = dst_addr & ~32'h3;
                    cnt_d   = len;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A zero-length copy passes through RUN for one cycle with
                // no bus activity and without raising busy, so its done
                // pulse lands two cycles after start like a normal copy's
                // pipeline would.
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    busy = 1'b1;
                    if (!hold) begin
                        rd_req = 1'b1;
                        src_d  = src_q + 32'd4;
                        cnt_d  = cnt_q - 1'b1;
                        if (cnt_q == LENWIDTH'(1)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wr_req_d       = rd_req;
        rd_addr_last_d = rd_req   ? src_q : rd_addr_last_q;
        wr_addr_last_d = wr_req_q ? dst_q : wr_addr_last_q;
    end

    // Bus outputs; addresses hold their last driven value between requests
    always_comb begin
        dmem.dmem_rd_req  = rd_req;
        dmem.dmem_rd_addr = rd_req ? src_q : rd_addr_last_q;
        dmem.dmem_wr_req  = wr_req_q;
        dmem.dmem_wr_addr = wr_req_q ? dst_q : wr_addr_last_q;
        dmem.dmem_wr_data = dmem.dmem_rd_data;
        dmem.dmem_wr_be   = wr_req_q ? 4'hF : 4'h0;
    end

endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma: a read-only memory model answers reads, a monitor logs
// every bus event, and each copy is compared against address/timing lists
// computed from the copy parameters and the hold pattern.
module tb_dmem_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'h0;
    logic [31:0] dst_addr = 32'h0;
    logic [15:0] len = 16'h0;
    logic        hold = 1'b0;
    logic        busy;
    logic        done;

    dmem_dma_if bus ();

    dmem_dma #(.LENWIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .hold     (hold),
        .busy     (busy),
        .done     (done),
        .dmem     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model: data for a read appears in the following cycle
    always @(posedge clk)
        bus.dmem_rd_data <= bus.dmem_rd_req ? mem_fn(bus.dmem_rd_addr) : 32'h0;

    typedef struct { int c; logic [31:0] addr; } rd_ev_t;
    typedef struct { int c; logic [31:0] addr; logic [31:0] data; logic [3:0] be; } wr_ev_t;

    rd_ev_t rd_log[$];
    wr_ev_t wr_log[$];
    int     done_log[$];
    int     busy_cnt = 0;
    int     misc_err = 0;
    logic [31:0] last_rd = 32'h0;
    logic [31:0] last_wr = 32'h0;
    logic        rst_prev = 1'b1;

    // Monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.dmem_rd_req === 1'b1) rd_log.push_back('{cyc, bus.dmem_rd_addr});
        else if (!rst_prev && bus.dmem_rd_addr !== last_rd) misc_err++;
        if (bus.dmem_wr_req === 1'b1)
            wr_log.push_back('{cyc, bus.dmem_wr_addr, bus.dmem_wr_data, bus.dmem_wr_be});
        else if (!rst_prev && bus.dmem_wr_addr !== last_wr) misc_err++;
        if (!rst_prev && bus.dmem_wr_be !== (bus.dmem_wr_req === 1'b1 ? 4'hF : 4'h0)) misc_err++;
        if (done === 1'b1) done_log.push_back(cyc);
        if (busy === 1'b1) busy_cnt++;
        last_rd  = bus.dmem_rd_addr;
        last_wr  = bus.dmem_wr_addr;
        rst_prev = reset;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        done_log.delete();
        busy_cnt = 0;
    endtask

    function automatic logic hbit(input logic [31:0] hm, input int k);
        return (k >= 1 && k <= 32) ? hm[k-1] : 1'b0;
    endfunction

    // One copy starting in the current cycle T. hm[k-1] is hold in cycle T+k.
    // noise drives start and scrambles the parameter inputs while the copy
    // is active. Returns in cycle T+done_off+1 (the IDLE cycle after FIN).
    task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                            input int l, input logic [31:0] hm, input bit noise);
        int rc[$];
        int c, i, t0, done_off, busy_exp;
        logic [31:0] sa, da;
        c = 1;
        i = 0;
        while (i < l) begin
            if (!hbit(hm, c)) begin
                rc.push_back(c);
                i++;
            end
            c++;
        end
        done_off = (l == 0) ? 2 : rc[l-1] + 2;
        busy_exp = (l == 0) ? 0 : rc[l-1] + 1;
        sa = s & ~32'h3;
        da = d & ~32'h3;

        clear_logs();
        t0       = cyc;
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = 16'(l);
        hold     = 1'b0;
        for (int k = 1; k <= done_off + 1; k++) begin
            step();
            hold = hbit(hm, k);
            if (noise && k <= done_off) begin
                start    = 1'($urandom_range(1));
                src_addr = $urandom;
                dst_addr = $urandom;
                len      = 16'($urandom_range(20));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        hold  = 1'b0;

        chk({name, " rd_count"}, 32'(rd_log.size()), 32'(l));
        for (int j = 0; j < l && j < rd_log.size(); j++) begin
            chk($sformatf("%s rd%0d_cycle", name, j), 32'(rd_log[j].c - t0), 32'(rc[j]));
            chk($sformatf("%s rd%0d_addr", name, j), rd_log[j].addr, sa + 32'(4 * j));
        end
        chk({name, " wr_count"}, 32'(wr_log.size()), 32'(l));
        for (int j = 0; j < l && j < wr_log.size(); j++) begin
            chk($sformatf("%s wr%0d_cycle", name, j), 32'(wr_log[j].c - t0), 32'(rc[j] + 1));
            chk($sformatf("%s wr%0d_addr", name, j), wr_log[j].addr, da + 32'(4 * j));
            chk($sformatf("%s wr%0d_data", name, j), wr_log[j].data, mem_fn(sa + 32'(4 * j)));
            chk($sformatf("%s wr%0d_be", name, j), 32'(wr_log[j].be), 32'hF);
        end
        chk({name, " done_count"}, 32'(done_log.size()), 32'd1);
        if (done_log.size() > 0)
            chk({name, " done_cycle"}, 32'(done_log[0] - t0), 32'(done_off));
        chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(busy_exp));
        chk({name, " bus_hold_be_errors"}, 32'(misc_err), 32'd0);
    endtask

    initial begin
        int t0;
        // Reset with start asserted: start must be ignored
        reset = 1'b1;
        start = 1'b1;
        len   = 16'd4;
        repeat (3) step();
        reset = 1'b0;
        start = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset rd_req", 32'(bus.dmem_rd_req), 32'd0);
        chk("reset wr_req", 32'(bus.dmem_wr_req), 32'd0);
        chk("reset wr_be", 32'(bus.dmem_wr_be), 32'd0);
        chk("reset rd_addr", bus.dmem_rd_addr, 32'd0);
        chk("reset wr_addr", bus.dmem_wr_addr, 32'd0);
        clear_logs();
        repeat (4) step();
        chk("post-reset idle rd", 32'(rd_log.size()), 32'd0);
        chk("post-reset idle done", 32'(done_log.size() + busy_cnt), 32'd0);

        run_copy("basic", 32'h100, 32'h200, 4, 32'h0, 1'b0);
        step();
        run_copy("zero_len", 32'h300, 32'h400, 0, 32'h0, 1'b0);
        step();
        run_copy("hold", 32'h500, 32'h600, 3, 32'h6, 1'b0);
        step();
        run_copy("wrap", 32'hFFFF_FFFE, 32'h13, 2, 32'h0, 1'b0);
        step();
        run_copy("restart_a", 32'h1000, 32'h2000, 5, 32'h0, 1'b1);
        run_copy("restart_b", 32'h3004, 32'h4008, 3, 32'h0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            logic [31:0] s, d, hm;
            int l;
            s  = $urandom;
            d  = s + 32'h0010_0000 + ($urandom & 32'h0000_FFFF);
            l  = $urandom_range(12);
            hm = ($urandom_range(1) == 1) ? $urandom : 32'h0;
            run_copy($sformatf("rand%0d", n), s, d, l, hm, 1'($urandom_range(1)));
            repeat ($urandom_range(2)) step();
        end

        // Reset asserted in T+2 of a len=8 copy
        clear_logs();
        t0       = cyc;
        start    = 1'b1;
        src_addr = 32'h400;
        dst_addr = 32'h800;
        len      = 16'd8;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset rd_req", 32'(bus.dmem_rd_req), 32'd0);
        chk("midreset wr_req", 32'(bus.dmem_wr_req), 32'd0);
        chk("midreset rd_addr", bus.dmem_rd_addr, 32'd0);
        chk("midreset wr_addr", bus.dmem_wr_addr, 32'd0);
        repeat (12) step();
        chk("midreset rd_count", 32'(rd_log.size()), 32'd2);
        chk("midreset wr_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() > 0)
            chk("midreset wr_cycle", 32'(wr_log[0].c - t0), 32'd2);
        chk("midreset done_count", 32'(done_log.size()), 32'd0);
        chk("midreset busy_cycles", 32'(busy_cnt), 32'd2);

        run_copy("after_reset", 32'h40, 32'h80, 2, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
